// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit.
//   - condition-code constants (EQ..NV) as used on it_cond / br_cond
//   - bit positions of N, Z, C, V inside the packed {N,Z,C,V} flag word
//   - FSM state enum for the block tracker
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flag word is {N,Z,C,V}, N in the MSB.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition decoder.
//   cond  : 4-bit condition code
//   flags : {N,Z,C,V}
//   pass  : 1 when the condition holds for the given flags
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: flag register, IT-style conditional block
// tracker and a registered branch-condition resolver.
//   clock, reset_n             : rising-edge clock, async active-low reset
//   flags_we, flags_in         : load {N,Z,C,V}; flags_out is the register
//   it_start/cond/len/pattern  : open a block (pattern bit i: 1=then, 0=else)
//   flush                      : abort any open block
//   instr_valid, exec_en       : retiring instruction and its execute enable
//   in_block, remaining, it_err: block status (registered)
//   br_valid, br_cond          : branch query; br_take/br_done one cycle later
//   state                      : current FSM state, for observation
//
// Handshake: every request input (it_start, instr_valid, br_valid, flush) is
// a single-cycle strobe sampled on the rising edge; there is no back-pressure,
// the unit accepts every cycle. br_done is a one-cycle valid qualifying br_take.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int MAX_BLOCK = 4,
  parameter int LEN_W     = $clog2(MAX_BLOCK + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flags_we,
  input  logic [3:0]           flags_in,
  output logic [3:0]           flags_out,
  input  logic                 it_start,
  input  logic [3:0]           it_cond,
  input  logic [LEN_W-1:0]     it_len,
  input  logic [MAX_BLOCK-1:0] it_pattern,
  input  logic                 flush,
  input  logic                 instr_valid,
  output logic                 exec_en,
  output logic                 in_block,
  output logic [LEN_W-1:0]     remaining,
  output logic                 it_err,
  input  logic                 br_valid,
  input  logic [3:0]           br_cond,
  output logic                 br_take,
  output logic                 br_done,
  output state_t               state
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BLOCK);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [3:0]           flags_q;
  state_t               state_q;
  logic [3:0]           cond_q;
  logic [MAX_BLOCK-1:0] pattern_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     remaining_q;
  logic                 it_err_q;
  logic                 br_take_q;
  logic                 br_done_q;

  logic                 blk_pass;
  logic                 br_pass;
  logic [LEN_W-1:0]     slot;
  logic [MAX_BLOCK-1:0] pattern_shift;
  logic                 never_else;
  logic                 start_ok;

  // Both paths read the registered flags, so a same-cycle flags_we is not seen.
  cond_eval u_blk_eval (.cond(cond_q),  .flags(flags_q), .pass(blk_pass));
  cond_eval u_br_eval  (.cond(br_cond), .flags(flags_q), .pass(br_pass));

  // Slot counts up from 0 while remaining counts down; shifting avoids a
  // variable bit-select whose index is wider than the pattern.
  assign slot          = len_q - remaining_q;
  assign pattern_shift = pattern_q >> slot;

  // The inverse of AL/NV is not a meaningful condition: else-slots never run.
  assign never_else = (cond_q == COND_AL) || (cond_q == COND_NV);

  assign start_ok = (state_q == ST_IDLE) && (it_len != '0) &&
                    (it_len <= MAX_LEN) && it_pattern[0];

  always_comb begin
    exec_en = 1'b0;
    if (instr_valid) begin
      if (state_q == ST_IDLE)    exec_en = 1'b1;
      else if (pattern_shift[0]) exec_en = blk_pass;
      else                       exec_en = !blk_pass && !never_else;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= '0;
      state_q     <= ST_IDLE;
      cond_q      <= '0;
      pattern_q   <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      it_err_q    <= 1'b0;
      br_take_q   <= 1'b0;
      br_done_q   <= 1'b0;
    end else begin
      if (flags_we) flags_q <= flags_in;

      br_done_q <= br_valid;
      if (br_valid) br_take_q <= br_pass;

      it_err_q <= 1'b0;
      if (flush) begin
        // Flush wins over a simultaneous start and never reports an error.
        state_q     <= ST_IDLE;
        remaining_q <= '0;
      end else begin
        if (state_q == ST_ACTIVE && instr_valid) begin
          remaining_q <= remaining_q - ONE;
          if (remaining_q == ONE) state_q <= ST_IDLE;
        end
        if (it_start) begin
          if (start_ok) begin
            state_q     <= ST_ACTIVE;
            cond_q      <= it_cond;
            pattern_q   <= it_pattern;
            len_q       <= it_len;
            remaining_q <= it_len;
          end else begin
            it_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign flags_out = flags_q;
  assign in_block  = (state_q == ST_ACTIVE);
  assign remaining = remaining_q;
  assign it_err    = it_err_q;
  assign br_take   = br_take_q;
  assign br_done   = br_done_q;
  assign state     = state_q;

endmodule
